lane_sweep_controller: RTL
==========================

Name: lane_sweep_controller

Overview:
- Sequencing controller for the lane-permutation stage of the state-array datapath. It is the parametrised successor of the single-pass line/shift controller.
- Sweeps a SIZE x SIZE lane array held in a two-bank memory (bank b occupies addresses b*SIZE*SIZE .. b*SIZE*SIZE+SIZE*SIZE-1).
- Each lane (x,y) is moved to (x'=y, y'=(MUL_X*x + MUL_Y*y) mod SIZE). The mod is computed by sequential repeated subtraction.
- Supports ROUNDS back-to-back passes with ping-pong banks, a datapath stall input and a start/busy/done handshake.

Parameters:
- SIZE, 5, array dimension; lanes per line and lines per array.
- MUL_X, 2, x coefficient of the destination-row formula.
- MUL_Y, 3, y coefficient of the destination-row formula.
- ROUNDS, 1, number of full sweeps per start; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- hold  in  1  datapath stall; freezes the FSM while high.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse in DONE.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDRW  read address; ADDRW = clog2(2*SIZE*SIZE).
- lat_en  out  1  latch read data into the lane register (one cycle after rd_en).
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDRW  write address.
- cur_round  out  RW  current round index; RW = clog2(ROUNDS+1).
- res_bank  out  1  bank holding the current or final result.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; x, y, acc, round, bank = 0; every output = 0.
- Widths: IDXW = clog2(SIZE). ACCW = clog2((MUL_X+MUL_Y)*(SIZE-1)+1). acc is unsigned; no overflow is possible at ACCW.
- Source address = src_bank*SIZE*SIZE + y*SIZE + x.
- Destination address = (~src_bank)*SIZE*SIZE + acc_final*SIZE + y.
- States:
  - IDLE: start=1 -> INIT. start is ignored in every other state.
  - INIT (1 cycle): x=0, y=0, round=0, src_bank=0, busy=1 -> READ.
  - READ (1 cycle): rd_en=1, rd_addr=source address -> MOD.
  - MOD: the first MOD cycle asserts lat_en and loads acc = MUL_X*x + MUL_Y*y. Each following cycle: if acc >= SIZE then acc -= SIZE and stay; else -> WRITE.
  - MOD cycle count = floor((MUL_X*x+MUL_Y*y)/SIZE) + 1. The check uses the loaded value, so the first cycle also subtracts if needed.
  - WRITE (1 cycle): wr_en=1, wr_addr=destination address -> NEXT.
  - NEXT (1 cycle): x+1. If x=SIZE-1, x wraps to 0 and y+1. If also y=SIZE-1, y wraps to 0 -> ROUND_END; otherwise -> READ.
  - ROUND_END (1 cycle): src_bank toggles, round+1. If the new round = ROUNDS -> DONE; otherwise -> READ.
  - DONE (1 cycle): done=1, busy still 1 -> IDLE, where busy=0.
- res_bank = src_bank; after completion it equals ROUNDS mod 2 and holds until the next start or reset.
- cur_round = round.
- hold=1 in any state other than IDLE:
  - state, x, y, acc and round are frozen; rd_en, wr_en, lat_en and done are forced to 0.
  - Addresses hold their values.
  - The frozen state re-issues its strobes in the first cycle with hold=0, so no read or write is lost or duplicated.
- hold in IDLE has no effect.
- A start pulse arriving together with hold=1 in IDLE is still accepted.
- Reset mid-operation aborts immediately with no further strobes; memory content is undefined.
- Strobes are Moore outputs, decoded from registered state only.

Test Plan:
- Reset/idle (defaults): rst=0 mid-MOD then released -> all outputs 0, state IDLE; start=0 for 10 cycles -> busy stays 0 with no strobes.
- Single lane map (SIZE=5, MUL_X=2, MUL_Y=3, ROUNDS=1), lane x=1,y=0: rd_addr=1, then 1 MOD cycle (acc=2), then wr_en with wr_addr=25+2*5+0=35.
- Max-mod lane x=4,y=4: rd_addr=24, acc=20, 5 MOD cycles, wr_addr=25+0*5+4=29. Check exactly one lat_en per lane.
- Full sweep, ROUNDS=1: exactly 25 rd_en and 25 wr_en. Write addresses are a permutation of 25..49. done pulses once; res_bank=1; busy drops the cycle after done; start during busy is ignored.
- ROUNDS=2: round 1 reads 25..49 and writes 0..24; cur_round steps 0 -> 1 -> 2; res_bank=0 at done; 50 reads and 50 writes total.
- Stall: hold=1 for 3 cycles while in WRITE -> wr_en=0 during hold with wr_addr stable, then exactly one wr_en pulse after release. Total write count is unchanged.

Source files
------------

// File: rtl/lane_sweep_controller.sv
// Lane-permutation sequencer: sweeps a SIZE x SIZE lane array between two memory
// banks, moving lane (x,y) to (y, (MUL_X*x + MUL_Y*y) mod SIZE) for ROUNDS passes.
module lane_sweep_controller #(
    parameter int SIZE   = 5,
    parameter int MUL_X  = 2,
    parameter int MUL_Y  = 3,
    parameter int ROUNDS = 1,
    localparam int ADDRW = $clog2(2*SIZE*SIZE),
    localparam int RW    = $clog2(ROUNDS+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ADDRW-1:0] rd_addr,
    output logic             lat_en,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [RW-1:0]    cur_round,
    output logic             res_bank
);

    localparam int IDXW = $clog2(SIZE);
    localparam int ACCW = $clog2((MUL_X+MUL_Y)*(SIZE-1)+1);
    localparam int SS   = SIZE*SIZE;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_READ, S_MOD, S_WRITE, S_NEXT, S_RND_END, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [IDXW-1:0] x, y;
    logic [ACCW-1:0] acc, load_val, mod_val;
    logic            first;
    logic [RW-1:0]   round;
    logic            bank;
    logic            mod_ge;
    logic [ADDRW-1:0] src_addr, dst_addr;

    // The first MOD cycle tests the freshly computed sum rather than the stale acc.
    always_comb begin
        load_val = ACCW'(MUL_X) * ACCW'(x) + ACCW'(MUL_Y) * ACCW'(y);
        mod_val  = first ? load_val : acc;
        mod_ge   = (mod_val >= ACCW'(SIZE));
        src_addr = (bank ? ADDRW'(SS) : '0) + ADDRW'(y) * ADDRW'(SIZE) + ADDRW'(x);
        dst_addr = (bank ? '0 : ADDRW'(SS)) + ADDRW'(acc) * ADDRW'(SIZE) + ADDRW'(y);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = S_INIT;
            S_INIT:    state_n = S_READ;
            S_READ:    state_n = S_MOD;
            S_MOD:     if (!mod_ge) state_n = S_WRITE;
            S_WRITE:   state_n = S_NEXT;
            S_NEXT:    state_n = (x == IDXW'(SIZE-1) && y == IDXW'(SIZE-1)) ? S_RND_END : S_READ;
            S_RND_END: state_n = (round == RW'(ROUNDS-1)) ? S_DONE : S_READ;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (hold && state != S_IDLE) state_n = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x     <= '0;
            y     <= '0;
            acc   <= '0;
            first <= 1'b0;
            round <= '0;
            bank  <= 1'b0;
        end else if (!hold) begin
            case (state)
                S_INIT: begin
                    x     <= '0;
                    y     <= '0;
                    round <= '0;
                    bank  <= 1'b0;
                end
                S_READ: first <= 1'b1;
                S_MOD: begin
                    first <= 1'b0;
                    acc   <= mod_ge ? mod_val - ACCW'(SIZE) : mod_val;
                end
                S_NEXT: begin
                    if (x == IDXW'(SIZE-1)) begin
                        x <= '0;
                        y <= (y == IDXW'(SIZE-1)) ? '0 : y + IDXW'(1);
                    end else begin
                        x <= x + IDXW'(1);
                    end
                end
                S_RND_END: begin
                    bank  <= ~bank;
                    round <= round + RW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE) && !hold;
        rd_en     = (state == S_READ) && !hold;
        lat_en    = (state == S_MOD) && first && !hold;
        wr_en     = (state == S_WRITE) && !hold;
        rd_addr   = (state == S_IDLE) ? '0 : src_addr;
        wr_addr   = (state == S_IDLE) ? '0 : dst_addr;
        cur_round = round;
        res_bank  = bank;
    end

endmodule
